uart_rx_os: RTL

- Serial-to-byte receiver that decodes the UART line feeding the command FSM of the UART/AES bridge.
- Frame format is 8N1: one start bit, 8 data bits LSB-first, one stop bit.
- Samples each bit at its centre with a 3-sample majority vote.
- Rejects glitch start bits and flags framing errors. Delivers each received byte as a one-cycle valid pulse.

---
 rtl/uart_rx_os.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with a synchronised line input and 3-sample majority voting at bit centre.
// Delivers each good byte as a one-cycle valid pulse and flags stop-bit errors with frame_err.
module uart_rx_os #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       valid,
   output logic [7:0] data,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(H);
   localparam logic [CW-1:0] CNT_S2   = CW'(H + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_vld_q;
   logic                   rx_s;
   logic                   sync_ok;
   logic                   maj;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [2:0]     bit_idx_q;
   logic [7:0]     shift_q;
   logic [1:0]     smp_q;
   logic           armed_q;
   logic           valid_q;
   logic           ferr_q;
   logic [7:0]     data_q;

   // Line synchroniser; sync_vld_q marks when the reset value of the chain has been flushed out.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '1;
         sync_vld_q <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
         sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign sync_ok = sync_vld_q[SYNC_STAGES-1];
   assign maj     = maj3(smp_q[0], smp_q[1], rx_s);

   // Receive FSM with bit counter, majority sampling and registered output pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         smp_q     <= 2'b00;
         armed_q   <= 1'b0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         data_q    <= 8'h00;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (cnt_q == CNT_S0) smp_q[0] <= rx_s;
         if (cnt_q == CNT_S1) smp_q[1] <= rx_s;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               // Only a high seen after the synchroniser has flushed arms the receiver.
               if (rx_s && sync_ok) armed_q <= 1'b1;
               if (armed_q && !rx_s) state_q <= START;
            end
            START: begin
               if (cnt_q == CNT_S2 && maj) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= DATA;
                  cnt_q     <= '0;
                  bit_idx_q <= 3'd0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == CNT_S2) shift_q <= {maj, shift_q[7:1]};
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (bit_idx_q == 3'd7) state_q <= STOP;
                  else                   bit_idx_q <= bit_idx_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (cnt_q == CNT_S2) begin
                  cnt_q <= '0;
                  if (maj) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WAIT_IDLE: begin
               cnt_q <= '0;
               if (rx_s) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign data      = data_q;
   assign busy      = (state_q != IDLE);

endmodule
